// File: rtl/bnn_axi_pkg.sv
// Shared definitions for the BNN AXI read sequencer.
//   AXI_BURST_INCR - ARBURST encoding for incrementing bursts
//   AXI_SIZE_4B    - ARSIZE encoding for 4-byte beats
//   AXI_4K_BYTES   - AXI page size; a burst may not cross this boundary
//   seq_state_t    - sequencer FSM states
package bnn_axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [12:0] AXI_4K_BYTES   = 13'd4096;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } seq_state_t;

endpackage

// File: rtl/bnn_burst_sizer.sv
// Combinational burst sizer: picks the beat count of the next burst as the
// smallest of the words still to fetch, the burst limit and the words left
// before the next 4 KB page boundary.
// Ports:
//   addr      in  12     page offset of the next burst start (word aligned)
//   remaining in  LEN_W  words still to fetch (non-zero when used)
//   beats     out 9      beats for the next burst, 1..MAX_BURST
module bnn_burst_sizer
  import bnn_axi_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 20
) (
  input  logic [11:0]      addr,
  input  logic [LEN_W-1:0] remaining,
  output logic [8:0]       beats
);

  logic [12:0] page_bytes;
  logic [10:0] page_beats;
  logic [10:0] lim;

  always_comb begin
    // 1..4096 bytes left in the page; the offset is word aligned so >= 1 beat
    page_bytes = AXI_4K_BYTES - {1'b0, addr};
    page_beats = 11'(page_bytes >> 2);
    lim        = 11'(MAX_BURST);
    if (page_beats < lim) lim = page_beats;
    if (32'(remaining) < 32'(lim)) lim = 11'(remaining);
    beats = 9'(lim);
  end

endmodule

// File: rtl/bnn_axi_read_sequencer.sv
// Fetch sequencer for the BNN accelerator on the M00 AXI4 read master.
// Splits a word transfer into INCR bursts that never cross a 4 KB page,
// keeps one burst outstanding, and passes R beats straight to the compute
// stream with no buffering.
// Ports:
//   clk, reset         system clock, async active-high reset
//   start              1-cycle request, honoured only in IDLE
//   base_addr          byte address of first word (bits [1:0] ignored)
//   num_words          words to fetch, sampled with start
//   busy / done        transfer in flight / 1-cycle completion pulse
//   error              sticky RRESP or RLAST fault, cleared by next start
//   m_axi_ar*          AR channel (registered, held stable until arready)
//   m_axi_r*           R channel (rready = out_ready while in DATA)
//   out_data/valid/    compute stream; out_last marks the final word
//   last/ready
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | present AR for the next burst (first cycle loads it, then hold)
// DATA  | forward R beats until the burst beat count runs out
// DONE  | one-cycle done pulse, then back to IDLE
module bnn_axi_read_sequencer
  import bnn_axi_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      m_axi_araddr,
  output logic [7:0]       m_axi_arlen,
  output logic [2:0]       m_axi_arsize,
  output logic [1:0]       m_axi_arburst,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [31:0]      m_axi_rdata,
  input  logic [1:0]       m_axi_rresp,
  input  logic             m_axi_rlast,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  seq_state_t       state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [8:0]       beat_cnt;
  logic [8:0]       beats;
  logic             beat_fire;

  bnn_burst_sizer #(
    .MAX_BURST (MAX_BURST),
    .LEN_W     (LEN_W)
  ) u_sizer (
    .addr      (addr[11:0]),
    .remaining (remaining),
    .beats     (beats)
  );

  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;

  // Zero-latency pass-through between R channel and the compute stream
  assign m_axi_rready = (state == DATA) & out_ready;
  assign out_valid    = (state == DATA) & m_axi_rvalid;
  assign out_data     = m_axi_rdata;
  assign out_last     = out_valid & (remaining == LEN_W'(1));
  assign beat_fire    = out_valid & out_ready;

  assign busy = (state == ADDR) || (state == DATA);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      error         <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (num_words != '0) begin
              addr      <= base_addr & 32'hFFFF_FFFC;
              remaining <= num_words;
              state     <= ADDR;
            end else begin
              state <= DONE;
            end
          end
        end
        ADDR: begin
          // Load AR from the sizer once, then hold it until the handshake
          if (!m_axi_arvalid) begin
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(beats - 9'd1);
            m_axi_arvalid <= 1'b1;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            beat_cnt      <= {1'b0, m_axi_arlen} + 9'd1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt  <= beat_cnt - 9'd1;
            remaining <= remaining - LEN_W'(1);
            addr      <= addr + 32'd4;
            if (m_axi_rresp != 2'b00) error <= 1'b1;
            // Our beat count ends the burst; rlast is only cross-checked
            if (m_axi_rlast != (beat_cnt == 9'd1)) error <= 1'b1;
            if (beat_cnt == 9'd1) begin
              state <= (remaining == LEN_W'(1)) ? DONE : ADDR;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_axi_read_sequencer.sv
// Scoreboard bench for bnn_axi_read_sequencer: expected AR requests and
// stream words are queued by the stimulus, a monitor pops and compares them
// as the DUT presents them, and a small AXI slave model returns read data.
module tb_bnn_axi_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [19:0] num_words;
  logic        busy, done, error;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_ready;

  always #5 clk = ~clk;

  bnn_axi_read_sequencer #(.MAX_BURST(16), .LEN_W(20)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } ar_t;

  ar_t         exp_ar[$];
  logic [32:0] exp_dat[$];   // {last, data}
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ar_cnt = 0;
  int ar_delay = 0;
  bit rand_ready = 1'b0;
  int err_beat = -1;
  int beat_idx = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ar(logic [31:0] a, logic [7:0] l);
    ar_t e;
    e.a = a;
    e.l = l;
    exp_ar.push_back(e);
  endtask

  task automatic push_words(logic [31:0] a, int n);
    for (int i = 0; i < n; i++)
      exp_dat.push_back({(i == n - 1), mem_word(a + 32'(4 * i))});
  endtask

  // AXI read slave: arready after ar_delay wait cycles, one burst at a time
  initial begin
    bit          arf, rf;
    logic [31:0] a_cap;
    logic [7:0]  l_cap;
    int          ar_wait;
    int          left;
    logic [31:0] saddr;
    ar_wait = 0;
    left = 0;
    saddr = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      arf = m_axi_arvalid & m_axi_arready;
      rf = m_axi_rvalid & m_axi_rready;
      a_cap = m_axi_araddr;
      l_cap = m_axi_arlen;
      @(posedge clk);
      #1;
      if (reset) begin
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        left = 0;
        ar_wait = 0;
      end else begin
        if (rf) begin
          left--;
          saddr += 4;
          beat_idx++;
        end
        if (arf) begin
          m_axi_arready = 1'b0;
          ar_wait = 0;
          left = int'(l_cap) + 1;
          saddr = a_cap;
        end else if (m_axi_arvalid && !m_axi_arready) begin
          if (ar_wait >= ar_delay) m_axi_arready = 1'b1;
          else ar_wait++;
        end
        m_axi_rvalid = (left > 0);
        m_axi_rdata = mem_word(saddr);
        m_axi_rresp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast = (left == 1);
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_wait;
    logic [31:0] prev_a;
    logic [7:0]  prev_l;
    ar_t         e;
    logic [32:0] d;
    prev_wait = 1'b0;
    prev_a = '0;
    prev_l = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("ar_stable_addr", m_axi_araddr, prev_a);
          check("ar_stable_len", m_axi_arlen, prev_l);
        end
        prev_wait = m_axi_arvalid & !m_axi_arready;
        prev_a = m_axi_araddr;
        prev_l = m_axi_arlen;
        if (m_axi_arvalid & m_axi_arready) begin
          ar_cnt++;
          if (exp_ar.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ar: got addr %0h len %0d, expected none", m_axi_araddr, m_axi_arlen);
          end else begin
            e = exp_ar.pop_front();
            check("araddr", m_axi_araddr, e.a);
            check("arlen", m_axi_arlen, e.l);
            check("arsize", m_axi_arsize, 3'b010);
            check("arburst", m_axi_arburst, 2'b01);
          end
        end
        if (out_valid) check("rready_tracks_out_ready", m_axi_rready, out_ready);
        if (out_valid & out_ready) begin
          if (exp_dat.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %0h, expected none", out_data);
          end else begin
            d = exp_dat.pop_front();
            check("out_data", out_data, d[31:0]);
            check("out_last", out_last, d[32]);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic do_start(logic [31:0] b, logic [19:0] n);
    @(posedge clk);
    #1;
    base_addr = b;
    num_words = n;
    beat_idx = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_done: got no done within %0d cycles, expected a pulse", name, budget);
    end
  endtask

  task automatic finish_xfer(string name, int budget, logic exp_err);
    int d0;
    d0 = done_cnt;
    wait_done(name, budget);
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
    check({name, "_words_left"}, 64'(exp_dat.size()), 64'd0);
    check({name, "_error"}, error, exp_err);
    check({name, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_error"}, error, 1'b0);
    check({name, "_arvalid"}, m_axi_arvalid, 1'b0);
    check({name, "_rready"}, m_axi_rready, 1'b0);
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_out_last"}, out_last, 1'b0);
    check({name, "_araddr"}, m_axi_araddr, 32'h0);
    check({name, "_arlen"}, m_axi_arlen, 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ar0;
    bit saw_arv, saw_busy;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // 1: three bursts 16/16/8
    push_ar(32'h1000_0000, 8'd15);
    push_ar(32'h1000_0040, 8'd15);
    push_ar(32'h1000_0080, 8'd7);
    push_words(32'h1000_0000, 40);
    do_start(32'h1000_0000, 20'd40);
    check("t1_busy", busy, 1'b1);
    finish_xfer("t1", 400, 1'b0);

    // 2: split at the 4 KB boundary
    push_ar(32'h0000_0FF0, 8'd3);
    push_ar(32'h0000_1000, 8'd3);
    push_words(32'h0000_0FF0, 8);
    do_start(32'h0000_0FF0, 20'd8);
    finish_xfer("t2", 200, 1'b0);

    // 3: zero-length transfer
    ar0 = ar_cnt;
    do_start(32'h0000_2000, 20'd0);
    check("t3_done_now", done, 1'b1);
    check("t3_busy_now", busy, 1'b0);
    saw_arv = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) saw_arv = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check("t3_no_arvalid", saw_arv, 1'b0);
    check("t3_no_busy", saw_busy, 1'b0);
    check("t3_no_ar", 64'(ar_cnt - ar0), 64'd0);

    // 4: RRESP error on beat 3, transfer still drains
    err_beat = 2;
    push_ar(32'h2000_0100, 8'd3);
    push_words(32'h2000_0100, 4);
    do_start(32'h2000_0100, 20'd4);
    finish_xfer("t4", 200, 1'b1);
    repeat (5) @(negedge clk);
    check("t4_error_sticky", error, 1'b1);
    err_beat = -1;

    // 5: random out_ready, arready delayed; base bits [1:0] dropped
    ar_delay = 5;
    rand_ready = 1'b1;
    push_ar(32'h3000_0FC0, 8'd15);
    push_ar(32'h3000_1000, 8'd3);
    push_words(32'h3000_0FC0, 20);
    do_start(32'h3000_0FC3, 20'd20);
    check("t5_error_cleared", error, 1'b0);
    finish_xfer("t5", 600, 1'b0);
    rand_ready = 1'b0;
    ar_delay = 0;

    // 6: reset mid-DATA, then a fresh transfer
    push_ar(32'h4000_0000, 8'd15);
    push_ar(32'h4000_0040, 8'd15);
    push_ar(32'h4000_0080, 8'd7);
    push_words(32'h4000_0000, 40);
    do_start(32'h4000_0000, 20'd40);
    for (int i = 0; i < 200 && exp_dat.size() > 34; i++) @(negedge clk);
    check("t6_mid_data", out_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    exp_ar.delete();
    exp_dat.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_ar(32'h5000_0000, 8'd3);
    push_words(32'h5000_0000, 4);
    do_start(32'h5000_0000, 20'd4);
    finish_xfer("t6", 200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
